mac_reg_arbiter: RTL and testbench

Round-robin arbiter sharing the single MAC register-access port (addr/wr_data/rdwn/request/done/rd_data) between NUM_REQ requesters, e.g. speed poller, PHY register access, host configuration. It replaces the static two-way mux in the MAC speed-control top level. Each transaction is locked until the MAC side reports done, and a watchdog guards the port against a MAC access that never completes.

---
 rtl/mac_ctrl_pkg.sv | 15 +
 rtl/rr_pick.sv | 35 +++
 rtl/mac_reg_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mac_reg_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC control blocks: arbiter FSM encoding and
// default register-access widths used by the access, PHY and poller blocks.
package mac_ctrl_pkg;

  localparam int MAC_ADDR_W = 14;
  localparam int MAC_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after i_ptr,
// wrapping modulo N. Reusable by any arbiter that keeps its own pointer.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int              j;
  logic [IW-1:0]   jj;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(i_ptr) + i;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!o_any && i_req[jj]) begin
        o_any       = 1'b1;
        o_grant[jj] = 1'b1;
        o_idx       = jj;
      end
    end
  end

endmodule

// File: rtl/mac_reg_arbiter.sv
// Round-robin arbiter sharing the MAC register-access port between NUM_REQ
// requesters; each transaction is locked until done or watchdog expiry.
module mac_reg_arbiter
  import mac_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = MAC_ADDR_W,
  parameter int DATA_W  = MAC_DATA_W,
  parameter int TIMEOUT = 1023
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_request,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wr_data,
  input  logic [NUM_REQ-1:0]        i_req_rdwn,
  output logic [NUM_REQ-1:0]        o_req_done,
  output logic                      o_req_err,
  output logic [DATA_W-1:0]         o_req_rd_data,
  output logic [ADDR_W-1:0]         o_mac_addr,
  output logic [DATA_W-1:0]         o_mac_wr_data,
  output logic                      o_mac_rdwn,
  output logic                      o_mac_request,
  input  logic                      i_mac_done,
  input  logic [DATA_W-1:0]         i_mac_rd_data,
  output logic [NUM_REQ-1:0]        o_grant,
  output logic                      o_busy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     idx_q, idx_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 rdwn_q, rdwn_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    rd_q, rd_d;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [PTR_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 sel_rdwn;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .i_req   (i_req_request),
    .i_ptr   (ptr_q),
    .o_grant (pick_grant),
    .o_idx   (pick_idx),
    .o_any   (pick_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_rdwn  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_grant[k]) begin
        sel_addr  = i_req_addr[k*ADDR_W +: ADDR_W];
        sel_wdata = i_req_wr_data[k*DATA_W +: DATA_W];
        sel_rdwn  = i_req_rdwn[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdwn_d  = rdwn_q;
    wd_d    = wd_q;
    err_d   = err_q;
    rd_d    = rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_grant;
          idx_d   = pick_idx;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          rdwn_d  = sel_rdwn;
          wd_d    = '0;
          err_d   = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A done arriving on the expiry cycle still completes normally.
        if (i_mac_done) begin
          rd_d    = i_mac_rd_data;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (wd_q == WD_LIMIT) begin
          rd_d    = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_DONE: begin
        ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + PTR_W'(1);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdwn_q  <= 1'b0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdwn_q  <= rdwn_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
    end
  end

  // Outputs decode the state flop directly, so reset clears them at once.
  assign o_mac_request = (state_q == ST_BUSY);
  assign o_busy        = (state_q == ST_BUSY) || (state_q == ST_DONE);
  assign o_grant       = o_busy ? grant_q : '0;
  assign o_req_done    = (state_q == ST_DONE) ? grant_q : '0;
  assign o_req_err     = (state_q == ST_DONE) && err_q;
  assign o_req_rd_data = rd_q;
  assign o_mac_addr    = addr_q;
  assign o_mac_wr_data = wdata_q;
  assign o_mac_rdwn    = rdwn_q;

endmodule

// File: tb/tb_mac_reg_arbiter.sv
// Directed bench for mac_reg_arbiter: grant order, latency, watchdog expiry,
// done/expiry collision and asynchronous reset mid-transaction.
module tb_mac_reg_arbiter;

  localparam int N  = 3;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_rdwn = '0;
  logic [N-1:0]    done;
  logic            err;
  logic [DW-1:0]   rd;
  logic [AW-1:0]   mac_addr;
  logic [DW-1:0]   mac_wdata;
  logic            mac_rdwn;
  logic            mac_req;
  logic            mac_done = 1'b0;
  logic [DW-1:0]   mac_rd = '0;
  logic [N-1:0]    grant;
  logic            busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int done_pulses = 0;
  int last_done_cyc = 0;
  int rise_cyc = 0;

  mac_reg_arbiter #(
    .NUM_REQ (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_request (req),
    .i_req_addr    (req_addr),
    .i_req_wr_data (req_wdata),
    .i_req_rdwn    (req_rdwn),
    .o_req_done    (done),
    .o_req_err     (err),
    .o_req_rd_data (rd),
    .o_mac_addr    (mac_addr),
    .o_mac_wr_data (mac_wdata),
    .o_mac_rdwn    (mac_rdwn),
    .o_mac_request (mac_req),
    .i_mac_done    (mac_done),
    .i_mac_rd_data (mac_rd),
    .o_grant       (grant),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (|done) done_pulses <= done_pulses + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic r);
    req_addr[k*AW +: AW]  = a;
    req_wdata[k*DW +: DW] = d;
    req_rdwn[k]           = r;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    req      = '0;
    mac_done = 1'b0;
    mac_rd   = '0;
    tick();
    tick();
    check("rst_mac_req", mac_req, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mac_addr", mac_addr, 0);
    check("rst_rd", rd, 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_rise();
    int n = 0;
    while (!mac_req && n < 40) begin
      tick();
      n++;
    end
    check("mac_req_rise", mac_req, 1);
    rise_cyc = cyc;
  endtask

  // One transaction: expected owner/address/direction, MAC latency, read data.
  task automatic serve(input int slot, input logic [AW-1:0] a, input logic r, input int lat,
                       input logic [DW-1:0] data, input bit drop, input bit chk_gap);
    logic [N-1:0] oh;
    oh = '0;
    oh[slot] = 1'b1;
    wait_rise();
    if (chk_gap) check("req_spacing", rise_cyc - last_done_cyc, 3);
    check("grant", grant, oh);
    check("mac_addr", mac_addr, a);
    check("mac_rdwn", mac_rdwn, r);
    repeat (lat - 1) tick();
    check("busy_hold", mac_req, 1);
    mac_done = 1'b1;
    mac_rd   = data;
    tick();
    last_done_cyc = cyc;
    mac_done = 1'b0;
    mac_rd   = '0;
    check("done_vec", done, oh);
    check("rd_data", rd, data);
    check("err", err, 0);
    check("mac_req_drop", mac_req, 0);
    if (drop) req[slot] = 1'b0;
  endtask

  initial begin
    int n;
    int t0;
    int pulses_before;

    // Single read from slot 1
    apply_reset();
    set_slot(1, 14'h0004, 32'h0, 1'b1);
    t0 = cyc;
    req = 3'b010;
    serve(1, 14'h0004, 1'b1, 5, 32'hDEADBEEF, 1'b1, 1'b0);
    check("grant_latency", rise_cyc - t0, 1);
    tick();
    check("gap_done", done, 0);
    check("gap_grant", grant, 0);
    check("gap_busy", busy, 0);

    // Three simultaneous requesters from reset
    apply_reset();
    set_slot(0, 14'h0001, 32'h0, 1'b1);
    set_slot(1, 14'h0002, 32'h0, 1'b1);
    set_slot(2, 14'h0003, 32'h0, 1'b1);
    req = 3'b111;
    serve(0, 14'h0001, 1'b1, 2, 32'h1000_0000, 1'b1, 1'b0);
    serve(1, 14'h0002, 1'b1, 3, 32'h2000_0000, 1'b1, 1'b1);
    serve(2, 14'h0003, 1'b1, 1, 32'h3000_0000, 1'b1, 1'b1);

    // Slot 0 continuous, slot 2 once: 0,2,0,0
    apply_reset();
    set_slot(0, 14'h000A, 32'h0, 1'b1);
    set_slot(2, 14'h000C, 32'h0, 1'b1);
    req = 3'b101;
    serve(0, 14'h000A, 1'b1, 2, 32'h0A0A_0001, 1'b0, 1'b0);
    serve(2, 14'h000C, 1'b1, 2, 32'h0C0C_0002, 1'b1, 1'b1);
    serve(0, 14'h000A, 1'b1, 2, 32'h0A0A_0003, 1'b0, 1'b1);
    serve(0, 14'h000A, 1'b1, 2, 32'h0A0A_0004, 1'b1, 1'b1);

    // Watchdog expiry, then next requester served normally
    apply_reset();
    set_slot(0, 14'h0100, 32'h0, 1'b1);
    set_slot(1, 14'h0200, 32'h0, 1'b1);
    mac_rd = 32'hA5A5_A5A5;
    req = 3'b001;
    wait_rise();
    n = 0;
    while (done == '0 && n < 40) begin
      tick();
      n++;
    end
    check("to_latency", cyc - rise_cyc, 17);
    check("to_done", done, 3'b001);
    check("to_err", err, 1);
    check("to_rd_zero", rd, 0);
    last_done_cyc = cyc;
    mac_rd = '0;
    req = 3'b010;
    serve(1, 14'h0200, 1'b1, 3, 32'h1111_2222, 1'b1, 1'b1);

    // Done coinciding with watchdog expiry (ptr now 2, only slot 1 asks)
    tick();
    tick();
    set_slot(1, 14'h0201, 32'h0, 1'b1);
    req = 3'b010;
    wait_rise();
    repeat (16) tick();
    mac_done = 1'b1;
    mac_rd   = 32'hCAFE_F00D;
    tick();
    mac_done = 1'b0;
    mac_rd   = '0;
    req      = '0;
    check("tie_latency", cyc - rise_cyc, 17);
    check("tie_done", done, 3'b010);
    check("tie_err", err, 0);
    check("tie_rd", rd, 32'hCAFE_F00D);
    tick();
    tick();

    // Write from slot 2 aborted by reset; ptr restarts at 0
    set_slot(1, 14'h0020, 32'h0, 1'b1);
    set_slot(2, 14'h0010, 32'h0000_1234, 1'b0);
    req = 3'b100;
    wait_rise();
    check("wr_grant", grant, 3'b100);
    check("wr_addr", mac_addr, 14'h0010);
    check("wr_data", mac_wdata, 32'h0000_1234);
    check("wr_rdwn", mac_rdwn, 0);
    tick();
    tick();
    pulses_before = done_pulses;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_req_drop", mac_req, 0);
    check("async_grant", grant, 0);
    check("async_busy", busy, 0);
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
    rst_n = 1'b1;
    check("no_done_on_reset", done_pulses, pulses_before);
    req = 3'b110;
    serve(1, 14'h0020, 1'b1, 2, 32'h5555_AAAA, 1'b1, 1'b0);
    req = '0;
    tick();
    tick();
    check("done_count", done_pulses, pulses_before + 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
